// File: rtl/ppsmon_pkg.sv
// rtl/ppsmon_pkg.sv - shared state encodings and register map for the PPS monitor
package ppsmon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOST  = 2'd3
    } pps_state_t;

    localparam logic [2:0] ADDR_MAXCOUNT = 3'd0;
    localparam logic [2:0] ADDR_TOL      = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_ERR      = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_EDGES    = 3'd5;
    localparam logic [2:0] ADDR_MIN      = 3'd6;
    localparam logic [2:0] ADDR_MAX      = 3'd7;

    localparam int STAT_EDGE  = 3;
    localparam int STAT_LOST  = 4;
    localparam int STAT_INTEN = 5;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ppsedge.sv
// rtl/ppsedge.sv - two-flop synchronizer and registered rising-edge pulse for i_pps
module ppsedge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pps,
    output logic o_edge
);
    logic sync1, sync2, prev;

    // Pulse appears three clocks after the raw input rises
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            o_edge <= 1'b0;
        end else begin
            sync1  <= i_pps;
            sync2  <= sync1;
            prev   <= sync2;
            o_edge <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/pps_monitor.sv
// rtl/pps_monitor.sv - PPS period monitor with lock tracking and bus register file
module pps_monitor
    import ppsmon_pkg::*;
#(
    parameter int          DW                 = 32,
    parameter int unsigned CLOCK_FREQUENCY_HZ = 100_000_000,
    parameter int unsigned DEFAULT_TOL        = 1000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_pps,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [2:0]      i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_locked,
    output logic            o_int
);
    pps_state_t  state, state_nxt;
    logic [31:0] ctr, period, err, maxcount, tol, edge_cnt, min_period, max_period;
    logic [15:0] missed;
    logic        edge_f, lost_f, int_en;
    logic        edge_f_nxt, lost_f_nxt, int_en_nxt;
    logic        edge_ev, in_tol, timeout, judged, lost_entry;
    logic        wr_en, wr_status, wr_minmax;
    logic [31:0] wdata, rdata;
    logic        unused_bus;

    assign unused_bus = &{1'b0, i_wb_cyc, i_wb_sel};
    assign o_wb_stall = 1'b0;
    assign wdata      = 32'(i_wb_data);

    ppsedge u_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pps   (i_pps),
        .o_edge  (edge_ev)
    );

    // Judgement uses the pre-write maxcount/tol so a same-cycle write cannot skew it
    assign in_tol     = (abs_diff(ctr, maxcount) <= tol);
    assign timeout    = ({1'b0, ctr} > ({1'b0, maxcount} + {1'b0, tol}));
    assign judged     = edge_ev && ((state == ST_ACQ) || (state == ST_TRACK));
    assign wr_en      = i_wb_stb && i_wb_we;
    assign wr_status  = wr_en && (i_wb_addr == ADDR_STATUS);
    assign wr_minmax  = wr_en && ((i_wb_addr == ADDR_MIN) || (i_wb_addr == ADDR_MAX));
    assign lost_entry = (state_nxt == ST_LOST) && (state != ST_LOST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (edge_ev) state_nxt = ST_ACQ;
            ST_ACQ:   if (edge_ev) state_nxt = in_tol ? ST_TRACK : ST_ACQ;
                      else if (timeout) state_nxt = ST_LOST;
            ST_TRACK: if (edge_ev) state_nxt = in_tol ? ST_TRACK : ST_ACQ;
                      else if (timeout) state_nxt = ST_LOST;
            ST_LOST:  if (edge_ev) state_nxt = ST_ACQ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Sticky flags: a same-cycle set overrides the write-1-to-clear
    always_comb begin
        edge_f_nxt = edge_f;
        lost_f_nxt = lost_f;
        int_en_nxt = int_en;
        if (wr_status) begin
            if (wdata[STAT_EDGE]) edge_f_nxt = 1'b0;
            if (wdata[STAT_LOST]) lost_f_nxt = 1'b0;
            int_en_nxt = wdata[STAT_INTEN];
        end
        if (edge_ev)    edge_f_nxt = 1'b1;
        if (lost_entry) lost_f_nxt = 1'b1;
    end

    always_comb begin
        rdata = '0;
        case (i_wb_addr)
            ADDR_MAXCOUNT: rdata = maxcount;
            ADDR_TOL:      rdata = tol;
            ADDR_PERIOD:   rdata = period;
            ADDR_ERR:      rdata = err;
            ADDR_STATUS:   rdata = {missed, 10'd0, int_en, lost_f, edge_f, o_locked, state};
            ADDR_EDGES:    rdata = edge_cnt;
            ADDR_MIN:      rdata = min_period;
            ADDR_MAX:      rdata = max_period;
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctr        <= '0;
            period     <= '0;
            err        <= '0;
            edge_cnt   <= '0;
            missed     <= '0;
            min_period <= '1;
            max_period <= '0;
            edge_f     <= 1'b0;
            lost_f     <= 1'b0;
            int_en     <= 1'b0;
            maxcount   <= CLOCK_FREQUENCY_HZ;
            tol        <= DEFAULT_TOL;
            o_wb_ack   <= 1'b0;
            o_wb_data  <= '0;
            o_locked   <= 1'b0;
            o_int      <= 1'b0;
        end else begin
            ctr <= edge_ev ? 32'd1 : ((ctr == '1) ? ctr : ctr + 32'd1);
            if (edge_ev) edge_cnt <= edge_cnt + 32'd1;
            if (judged) begin
                period <= ctr;
                err    <= ctr - maxcount;
            end
            if (lost_entry && (missed != '1)) missed <= missed + 16'd1;

            if (wr_minmax) begin
                min_period <= '1;
                max_period <= '0;
            end else if (judged) begin
                if (ctr < min_period) min_period <= ctr;
                if (ctr > max_period) max_period <= ctr;
            end

            edge_f   <= edge_f_nxt;
            lost_f   <= lost_f_nxt;
            int_en   <= int_en_nxt;
            o_locked <= (state_nxt == ST_TRACK);
            o_int    <= int_en_nxt & (edge_f_nxt | lost_f_nxt);

            if (wr_en && (i_wb_addr == ADDR_MAXCOUNT)) maxcount <= wdata;
            if (wr_en && (i_wb_addr == ADDR_TOL))      tol      <= wdata;

            o_wb_ack <= i_wb_stb;
            if (i_wb_stb) o_wb_data <= DW'(rdata);
        end
    end

endmodule

// File: tb/tb_pps_monitor.sv
// tb/tb_pps_monitor.sv - randomized and directed bench for pps_monitor against a behavioural model
module tb_pps_monitor;
    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned DTOL   = 7;

    logic        clk = 1'b0, rst = 1'b1, pps = 1'b0;
    logic        wb_cyc, wb_stb = 1'b0, wb_we = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [3:0]  wb_sel = 4'hF;
    logic        wb_stall, wb_ack, locked, irq;
    logic [31:0] wb_rdata;

    int checks = 0, failures = 0;

    assign wb_cyc = wb_stb;
    always #5 clk = ~clk;

    pps_monitor #(.DW(32), .CLOCK_FREQUENCY_HZ(CLK_HZ), .DEFAULT_TOL(DTOL)) dut (
        .i_clk(clk), .i_reset(rst), .i_pps(pps),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
        .o_wb_stall(wb_stall), .o_wb_ack(wb_ack), .o_wb_data(wb_rdata),
        .o_locked(locked), .o_int(irq)
    );

    // Behavioural model: state 0=IDLE 1=ACQ 2=TRACK 3=LOST
    int          m_state;
    logic [31:0] m_ctr, m_period, m_err, m_maxcnt, m_tol, m_edges, m_min, m_maxp, m_rdata;
    logic [15:0] m_missed;
    bit          m_edge_f, m_lost_f, m_int_en, m_locked, m_int, m_ack;
    bit          rise_q[$];
    bit          pps_last;
    int          gap_q[$];
    int          since_rise = 1000;
    int          n_rises = 0;
    bit          rand_bus = 0;

    function automatic void model_reset();
        m_state = 0; m_ctr = 0; m_period = 0; m_err = 0; m_edges = 0; m_missed = 0;
        m_min = 32'hFFFF_FFFF; m_maxp = 0; m_maxcnt = CLK_HZ; m_tol = DTOL;
        m_edge_f = 0; m_lost_f = 0; m_int_en = 0; m_locked = 0; m_int = 0;
        m_ack = 0; m_rdata = 0;
        rise_q.delete();
        repeat (3) rise_q.push_back(1'b0);
        pps_last = 0;
    endfunction

    function automatic logic [31:0] reg_value(input logic [2:0] a);
        case (a)
            3'd0: return m_maxcnt;
            3'd1: return m_tol;
            3'd2: return m_period;
            3'd3: return m_err;
            3'd4: return {m_missed, 10'd0, m_int_en, m_lost_f, m_edge_f, m_locked, 2'(m_state)};
            3'd5: return m_edges;
            3'd6: return m_min;
            default: return m_maxp;
        endcase
    endfunction

    function automatic void model_step();
        bit ev, in_tol, timeout, wr, lost_entry;
        int nstate;
        longint d;
        // An input rise reaches the monitor as an edge three clocks later
        ev = rise_q.pop_front();
        rise_q.push_back(pps && !pps_last);
        pps_last = pps;
        d = longint'(m_ctr) - longint'(m_maxcnt);
        if (d < 0) d = -d;
        in_tol  = (d <= longint'(m_tol));
        timeout = (longint'(m_ctr) > longint'(m_maxcnt) + longint'(m_tol));
        wr = wb_stb && wb_we;
        m_ack = wb_stb;
        if (wb_stb) m_rdata = reg_value(wb_addr);
        nstate = m_state;
        if (ev) nstate = (m_state == 0 || m_state == 3) ? 1 : (in_tol ? 2 : 1);
        else if ((m_state == 1 || m_state == 2) && timeout) nstate = 3;
        if (ev && (m_state == 1 || m_state == 2)) begin
            m_period = m_ctr;
            m_err    = m_ctr - m_maxcnt;
            if (m_ctr < m_min)  m_min  = m_ctr;
            if (m_ctr > m_maxp) m_maxp = m_ctr;
        end
        lost_entry = (nstate == 3) && (m_state != 3);
        if (lost_entry && m_missed != 16'hFFFF) m_missed = m_missed + 1;
        if (ev) m_edges = m_edges + 1;
        m_ctr = ev ? 32'd1 : ((m_ctr == 32'hFFFF_FFFF) ? m_ctr : m_ctr + 1);
        if (wr && wb_addr == 3'd4) begin
            if (wb_wdata[3]) m_edge_f = 0;
            if (wb_wdata[4]) m_lost_f = 0;
            m_int_en = wb_wdata[5];
        end
        if (ev) m_edge_f = 1;
        if (lost_entry) m_lost_f = 1;
        if (wr && wb_addr >= 3'd6) begin
            m_min = 32'hFFFF_FFFF;
            m_maxp = 0;
        end
        if (wr && wb_addr == 3'd0) m_maxcnt = wb_wdata;
        if (wr && wb_addr == 3'd1) m_tol = wb_wdata;
        m_state  = nstate;
        m_locked = (nstate == 2);
        m_int    = m_int_en && (m_edge_f || m_lost_f);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check("ack", wb_ack, m_ack);
        check("stall", wb_stall, 32'd0);
        check("locked", locked, m_locked);
        check("int", irq, m_int);
        if (m_ack) check("rdata", wb_rdata, m_rdata);
        wb_stb = 0;
        wb_we  = 0;
        if (rand_bus && $urandom_range(0, 2) == 0) begin
            wb_stb  = 1;
            wb_addr = 3'($urandom_range(0, 7));
            wb_we   = ($urandom_range(0, 3) == 0);
            case (wb_addr)
                3'd0:    wb_wdata = 32'($urandom_range(97, 103));
                3'd1:    wb_wdata = 32'($urandom_range(0, 4));
                default: wb_wdata = $urandom;
            endcase
        end
        since_rise++;
        if (gap_q.size() > 0 && since_rise >= gap_q[0]) begin
            void'(gap_q.pop_front());
            since_rise = 0;
            n_rises++;
        end
        pps = (since_rise < 4);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        wb_stb = 1; wb_we = 0; wb_addr = a;
        tick();
        d = wb_rdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wb_stb = 1; wb_we = 1; wb_addr = a; wb_wdata = d;
        tick();
    endtask

    task automatic settle();
        while (gap_q.size() > 0) tick();
        repeat (6) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        model_reset();
        repeat (3) tick();
        check("reset locked", locked, 0);
        check("reset int", irq, 0);
        check("reset rdata", wb_rdata, 0);
        rst = 0;
        tick();
        rd(3'd0, d); check("reset maxcount", d, 32'd1000);
        rd(3'd1, d); check("reset tol", d, 32'd7);
        rd(3'd6, d); check("reset min", d, 32'hFFFF_FFFF);
        rd(3'd4, d); check("reset status", d, 32'd0);
        wr(3'd0, 32'd100);
        wr(3'd1, 32'd2);

        // Lock acquisition with 100-cycle edges
        gap_q.push_back(10); settle();
        rd(3'd4, d); check("first edge state", d[2:0], 3'b001);
        rd(3'd2, d); check("first edge period", d, 32'd0);
        gap_q.push_back(100); settle();
        rd(3'd4, d); check("second edge track", d[2:0], 3'b110);
        gap_q.push_back(100); settle();
        rd(3'd2, d); check("track period", d, 32'd100);
        rd(3'd3, d); check("track err", d, 32'd0);
        check("track locked", locked, 1);

        // Short gap drops to ACQ, next good edge relocks
        gap_q.push_back(97); settle();
        rd(3'd2, d); check("short period", d, 32'd97);
        rd(3'd3, d); check("short err", d, 32'hFFFF_FFFD);
        rd(3'd4, d); check("short state", d[2:0], 3'b001);
        gap_q.push_back(100); settle();
        rd(3'd4, d); check("relock state", d[2:0], 3'b110);

        // Min/max tracking and clear
        wr(3'd6, 32'd0);
        gap_q.push_back(99); gap_q.push_back(101); gap_q.push_back(100); settle();
        rd(3'd6, d); check("min period", d, 32'd99);
        rd(3'd7, d); check("max period", d, 32'd101);
        wr(3'd7, 32'd0);
        rd(3'd6, d); check("min cleared", d, 32'hFFFF_FFFF);
        rd(3'd7, d); check("max cleared", d, 32'd0);

        // Loss of signal with interrupt
        wr(3'd4, 32'h28);
        check("int idle", irq, 0);
        repeat (110) tick();
        rd(3'd4, d);
        check("lost state", d[1:0], 2'd3);
        check("lost flag", d[4], 1'b1);
        check("missed one", d[31:16], 16'd1);
        check("lost int", irq, 1);
        wr(3'd4, 32'h10);
        check("int cleared", irq, 0);
        rd(3'd4, d); check("lost flag cleared", d[4], 1'b0);

        // Tolerance boundary: 102 stays locked, 103 collides with timeout and edge wins
        gap_q.push_back(10); gap_q.push_back(100); settle();
        gap_q.push_back(102); settle();
        rd(3'd4, d); check("edge 102 track", d[1:0], 2'd2);
        gap_q.push_back(103); settle();
        rd(3'd4, d);
        check("edge 103 acq", d[1:0], 2'd1);
        check("edge 103 missed", d[31:16], 16'd1);
        check("edge 103 no lost", d[4], 1'b0);

        // Reset mid-interval
        gap_q.push_back(100); settle();
        repeat (30) tick();
        wb_stb = 1; wb_we = 0; wb_addr = 3'd2;
        tick();
        check("pre-reset locked", locked, 1);
        rst = 1;
        model_reset();
        #1;
        check("async reset locked", locked, 0);
        check("async reset ack", wb_ack, 0);
        check("async reset rdata", wb_rdata, 0);
        check("async reset int", irq, 0);
        repeat (3) tick();
        rst = 0;
        n_rises = 0;
        tick();
        gap_q.push_back(20); settle();
        rd(3'd4, d); check("post-reset state", d[2:0], 3'b001);
        rd(3'd2, d); check("post-reset period", d, 32'd0);

        // Randomized run
        wr(3'd0, 32'd100);
        wr(3'd1, 32'd3);
        rand_bus = 1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) gap_q.push_back(140);
            else gap_q.push_back(int'($urandom_range(96, 106)));
        end
        settle();
        rand_bus = 0;
        tick();
        rd(3'd5, d); check("edge count", d, 32'(n_rises));
        check("edge count total", n_rises, 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pps_monitor.md
PPS_MONITOR -- requirements
Module: pps_monitor

Interface
REQ-001 SHALL have parameter DW, default 32, bus data width.
REQ-002 SHALL have parameter CLOCK_FREQUENCY_HZ, default 100_000_000, reset value of the nominal period register.
REQ-003 SHALL have parameter DEFAULT_TOL, default 1000, reset value of the tolerance register, in cycles.
REQ-004 i_clk  in  1  single clock; all state on posedge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_pps  in  1  external pulse-per-second input, asynchronous to i_clk.
REQ-007 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  bus control.
REQ-008 i_wb_addr  in  3; i_wb_data  in  DW; i_wb_sel  in  DW/8 (ignored).
REQ-009 o_wb_stall  out  1; o_wb_ack  out  1; o_wb_data  out  DW.
REQ-010 o_locked  out  1  high while state is TRACK.
REQ-011 o_int  out  1  level interrupt.

Function
REQ-012 i_pps SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce a one-cycle edge event, 3 cycles after the i_pps rise.
REQ-013 Cycle counter ctr (32 bit): on an edge event, period <= ctr and ctr <= 1; otherwise ctr <= ctr+1, saturating at 32'hFFFF_FFFF; edges N cycles apart SHALL latch period = N.
REQ-014 err SHALL be period minus maxcount as 32-bit two's complement, updated with period.
REQ-015 An edge is "in tolerance" when |period - maxcount| <= tol, computed on the values held before that cycle's bus write.
REQ-016 States: IDLE=0, ACQ=1, TRACK=2, LOST=3.
REQ-017 IDLE -> ACQ on first edge; period/err not updated by this edge.
REQ-018 ACQ -> TRACK on an in-tolerance edge; ACQ stays ACQ on an out-of-tolerance edge.
REQ-019 TRACK stays TRACK on an in-tolerance edge; TRACK -> ACQ on an out-of-tolerance edge.
REQ-020 ACQ or TRACK -> LOST when ctr > maxcount+tol with no edge; missed count (16 bit, saturating) increments once per entry into LOST.
REQ-021 LOST -> ACQ on the next edge; that edge updates nothing but ctr.
REQ-022 Edge and timeout in the same cycle: the edge wins; no LOST entry.
REQ-023 min/max period SHALL update on every edge judged in ACQ or TRACK; a write to addr 6 or 7 SHALL set min to 32'hFFFF_FFFF and max to 0.
REQ-024 Sticky flags: EDGE set on every edge event, LOSTF set on LOST entry; if set and clear coincide, set wins.
REQ-025 o_int SHALL equal int_en AND (EDGE OR LOSTF), registered.
REQ-026 Register map: 0 maxcount RW; 1 tol RW; 2 period RO; 3 err RO; 4 status; 5 edge count RO (32 bit, wrapping); 6 min RO; 7 max RO.
REQ-027 Status read: [1:0] state, [2] o_locked, [3] EDGE, [4] LOSTF, [5] int_en, [31:16] missed count; write: [3],[4] write-1-to-clear, [5] written directly.
REQ-028 o_wb_ack SHALL be i_wb_stb delayed one cycle; o_wb_data SHALL be registered and valid with ack; o_wb_stall SHALL be constant 0.
REQ-029 Writes SHALL require i_wb_stb and i_wb_we; i_wb_cyc and i_wb_sel are unused.

Reset
REQ-030 i_reset SHALL asynchronously force: state IDLE, ctr 0, period 0, err 0, edge/missed counts 0, min 32'hFFFF_FFFF, max 0, flags and int_en 0, synchronizer flops 0, maxcount CLOCK_FREQUENCY_HZ, tol DEFAULT_TOL, o_wb_ack 0, o_wb_data 0, o_locked 0, o_int 0.
REQ-031 A reset asserted mid-measurement SHALL discard the partial interval; the first edge after release SHALL only enter ACQ.

Structure
REQ-032 State encodings and register address constants SHALL live in shared package ppsmon_pkg.
REQ-033 Synchronizer plus edge detector SHALL be sub-module ppsedge (i_clk, i_reset, i_pps, o_edge).

Verification
REQ-034 maxcount=100, tol=2, edges every 100 cycles -> IDLE, ACQ, TRACK after second edge; period=100, err=0, o_locked=1.
REQ-035 In TRACK, one gap of 97 cycles -> period=97, err=32'hFFFF_FFFD, state ACQ, o_locked=0; next 100-cycle edge -> TRACK.
REQ-036 In TRACK, stop i_pps -> LOST when ctr=103, missed=1, LOSTF=1; int_en=1 gives o_int=1; writing status 0x10 clears LOSTF and o_int.
REQ-037 Edge arriving exactly when ctr=103 -> treated as edge, state ACQ, missed unchanged.
REQ-038 Periods 99,101,100 in TRACK -> min=99, max=101; write addr 6 -> min=32'hFFFF_FFFF, max=0.
REQ-039 Assert i_reset mid-interval -> all outputs at reset values same cycle; first subsequent edge -> ACQ, period stays 0.
